exec_core: RTL and testbench



---
 rtl/exec_core.sv | 152 +++++++++++++++
 tb/tb_exec_core.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_core.sv
// Execution core: GPR file, SGPR, flags and ALU behind a valid/ready instruction port.
// MUL is a shift-add multiplier taking DATA_W cycles; its high half lands in SGPR.
module exec_core #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned REG_AW    = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op,
  input  logic              imm_mode,
  input  logic [REG_AW-1:0] rdst,
  input  logic [REG_AW-1:0] rsrc1,
  input  logic [REG_AW-1:0] rsrc2,
  input  logic [DATA_W-1:0] imm,
  output logic              done,
  output logic              ill_op,
  output logic [3:0]        flags,
  output logic [DATA_W-1:0] sgpr,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  localparam logic [4:0] OpMovSgpr = 5'd0;
  localparam logic [4:0] OpMov     = 5'd1;
  localparam logic [4:0] OpAdd     = 5'd2;
  localparam logic [4:0] OpSub     = 5'd3;
  localparam logic [4:0] OpMul     = 5'd4;
  localparam logic [4:0] OpOr      = 5'd5;
  localparam logic [4:0] OpAnd     = 5'd6;
  localparam logic [4:0] OpXor     = 5'd7;
  localparam logic [4:0] OpXnor    = 5'd8;
  localparam logic [4:0] OpNand    = 5'd9;
  localparam logic [4:0] OpNor     = 5'd10;
  localparam logic [4:0] OpNot     = 5'd11;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   gpr_q [REG_COUNT];
  logic [2*DATA_W-1:0] acc_q;
  logic [2*DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [CntW-1:0]     cnt_q;
  logic [REG_AW-1:0]   dst_q;

  logic [DATA_W-1:0]   opa, opb, res;
  logic [DATA_W:0]     sum, diff;
  logic                res_c, res_v, legal;
  logic [2*DATA_W-1:0] acc_nxt;
  logic [DATA_W-1:0]   prod_hi;

  assign in_ready = (state_q == StIdle);
  assign dbg_data = gpr_q[dbg_addr];

  assign opa  = gpr_q[rsrc1];
  assign opb  = imm_mode ? imm : gpr_q[rsrc2];
  assign sum  = {1'b0, opa} + {1'b0, opb};
  // Top bit of the extended difference is the unsigned borrow.
  assign diff = {1'b0, opa} - {1'b0, opb};

  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_hi = acc_nxt[2*DATA_W-1:DATA_W];

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    legal = 1'b1;
    case (op)
      OpMovSgpr: res = sgpr;
      OpMov:     res = opb;
      OpAdd: begin
        res   = sum[DATA_W-1:0];
        res_c = sum[DATA_W];
        res_v = (opa[DATA_W-1] == opb[DATA_W-1]) && (res[DATA_W-1] != opa[DATA_W-1]);
      end
      OpSub: begin
        res   = diff[DATA_W-1:0];
        res_c = diff[DATA_W];
        res_v = (opa[DATA_W-1] != opb[DATA_W-1]) && (res[DATA_W-1] != opa[DATA_W-1]);
      end
      OpMul:     res = '0;
      OpOr:      res = opa | opb;
      OpAnd:     res = opa & opb;
      OpXor:     res = opa ^ opb;
      OpXnor:    res = ~(opa ^ opb);
      OpNand:    res = ~(opa & opb);
      OpNor:     res = ~(opa | opb);
      OpNot:     res = ~opb;
      default:   legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) gpr_q[i] <= '0;
      sgpr     <= '0;
      flags    <= '0;
      done     <= 1'b0;
      ill_op   <= 1'b0;
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      dst_q    <= '0;
    end else begin
      done   <= 1'b0;
      ill_op <= 1'b0;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (op == OpMul) begin
              mcand_q  <= {{DATA_W{1'b0}}, opa};
              mplier_q <= opb;
              acc_q    <= '0;
              cnt_q    <= CntW'(DATA_W);
              dst_q    <= rdst;
              state_q  <= StMul;
            end else if (legal) begin
              gpr_q[rdst] <= res;
              flags       <= {res[DATA_W-1], res == '0, res_c, res_v};
              done        <= 1'b1;
            end else begin
              ill_op <= 1'b1;
            end
          end
        end
        StMul: begin
          acc_q    <= acc_nxt;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            gpr_q[dst_q] <= acc_nxt[DATA_W-1:0];
            sgpr         <= prod_hi;
            flags        <= {acc_nxt[2*DATA_W-1], acc_nxt == '0, |prod_hi, |prod_hi};
            done         <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_core.sv
// Randomised scoreboard bench for exec_core: a driver pushes expected commits from an
// arithmetic reference model; a monitor pops and compares on every done/ill_op pulse.
module tb_exec_core;

  localparam int DW = 16;
  localparam int RC = 32;
  localparam int AW = $clog2(RC);

  logic          clk = 1'b0;
  logic          sys_rst;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    op;
  logic          imm_mode;
  logic [AW-1:0] rdst, rsrc1, rsrc2;
  logic [DW-1:0] imm;
  logic          done, ill_op;
  logic [3:0]    flags;
  logic [DW-1:0] sgpr;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  logic [AW-1:0] mon_addr, drv_addr;
  logic          mon_busy = 1'b0;
  assign dbg_addr = mon_busy ? mon_addr : drv_addr;

  exec_core #(.DATA_W(DW), .REG_COUNT(RC)) dut (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .imm_mode (imm_mode),
    .rdst     (rdst),
    .rsrc1    (rsrc1),
    .rsrc2    (rsrc2),
    .imm      (imm),
    .done     (done),
    .ill_op   (ill_op),
    .flags    (flags),
    .sgpr     (sgpr),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            ill;
    int            due;
    logic [AW-1:0] rdst;
    logic [DW-1:0] val;
    logic [DW-1:0] sg;
    logic [3:0]    fl;
  } exp_t;

  exp_t          sbq[$];
  logic [DW-1:0] m_gpr[RC];
  logic [DW-1:0] m_sgpr;
  logic [3:0]    m_flags;
  int            checks = 0;
  int            passed = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < RC; i++) m_gpr[i] = '0;
    m_sgpr  = '0;
    m_flags = '0;
  endfunction

  function automatic bit ovf(input longint sr);
    longint half = 64'sd1 <<< (DW - 1);
    return (sr >= half) || (sr < -half);
  endfunction

  // Expected effect of one accepted instruction, from plain integer arithmetic.
  function automatic void model(input logic [4:0] o, input logic im, input logic [AW-1:0] rd,
                                input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                                input logic [DW-1:0] iv);
    exp_t   e;
    longint mask = (64'sd1 <<< DW) - 1;
    longint half = 64'sd1 <<< (DW - 1);
    longint a = longint'(m_gpr[r1]);
    longint b = im ? longint'(iv) : longint'(m_gpr[r2]);
    longint sa = (a >= half) ? a - 2 * half : a;
    longint sb = (b >= half) ? b - 2 * half : b;
    longint r = 0;
    longint p = 0;
    bit c = 0, v = 0, s = 0, z = 0;
    e.ill  = 0;
    e.due  = cyc + 1;
    e.rdst = rd;
    case (o)
      5'd0:  r = longint'(m_sgpr);
      5'd1:  r = b;
      5'd2:  begin r = a + b; c = (r > mask); v = ovf(sa + sb); end
      5'd3:  begin r = a - b; c = (a < b);    v = ovf(sa - sb); end
      5'd4:  p = a * b;
      5'd5:  r = a | b;
      5'd6:  r = a & b;
      5'd7:  r = a ^ b;
      5'd8:  r = ~(a ^ b);
      5'd9:  r = ~(a & b);
      5'd10: r = ~(a | b);
      5'd11: r = ~b;
      default: e.ill = 1;
    endcase
    if (o == 5'd4) begin
      r      = p & mask;
      m_sgpr = DW'(p >>> DW);
      s      = ((p >>> (2 * DW - 1)) & 1) != 0;
      z      = (p == 0);
      c      = (p >>> DW) != 0;
      v      = c;
      e.due  = e.due + DW;
    end else begin
      r = r & mask;
      s = ((r >>> (DW - 1)) & 1) != 0;
      z = (r == 0);
    end
    if (!e.ill) begin
      m_gpr[rd] = DW'(r);
      m_flags   = {s, z, c, v};
    end
    e.val = m_gpr[rd];
    e.sg  = m_sgpr;
    e.fl  = m_flags;
    sbq.push_back(e);
  endfunction

  task automatic issue(input logic [4:0] o, input logic im, input logic [AW-1:0] rd,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                       input logic [DW-1:0] iv);
    int n;
    op = o; imm_mode = im; rdst = rd; rsrc1 = r1; rsrc2 = r2; imm = iv;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", in_ready, 1);
    model(o, im, rd, r1, r2, iv);
    @(posedge clk);
    @(negedge clk);
    if (o == 5'd4) begin
      // Present a different instruction while busy; it must be ignored.
      op = 5'd2; imm_mode = 1'b1; rdst = AW'($urandom); imm = DW'($urandom);
      n = 0;
      while (!in_ready && n < 4 * DW) begin
        n++;
        @(negedge clk);
      end
      chk("mul_busy_cycles", n, DW);
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [DW-1:0] pick_imm();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(DW - 1){1'b0}}};
      default: return DW'($urandom);
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sys_rst) continue;
      if (done || ill_op) begin
        chk("done_ill_exclusive", done & ill_op, 0);
        if (sbq.size() == 0) begin
          chk("spurious_output", {done, ill_op}, 0);
        end else begin
          e = sbq.pop_front();
          chk("ill_op_kind", ill_op, e.ill);
          chk("latency", cyc, e.due);
          mon_addr = e.rdst;
          mon_busy = 1'b1;
          #1;
          chk("gpr_value", dbg_data, e.val);
          chk("flags", flags, e.fl);
          chk("sgpr", sgpr, e.sg);
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin : driver
    logic [4:0] o;
    sys_rst = 1'b1; in_valid = 1'b0; op = '0; imm_mode = 1'b0;
    rdst = '0; rsrc1 = '0; rsrc2 = '0; imm = '0; drv_addr = '0; mon_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    sys_rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_ill_op", ill_op, 0);
    chk("rst_flags", flags, 0);
    chk("rst_sgpr", sgpr, 0);
    for (int i = 0; i < 4; i++) begin
      drv_addr = AW'(i * 7);
      #1;
      chk("rst_gpr", dbg_data, 0);
    end

    // Directed scenarios.
    for (int i = 0; i < RC; i++) issue(5'd1, 1'b1, AW'(i), '0, '0, DW'(2));
    issue(5'd2, 1'b1, AW'(0), AW'(2), '0, DW'(4));
    issue(5'd1, 1'b1, AW'(4), '0, '0, DW'(55));
    issue(5'd1, 1'b0, AW'(4), AW'(7), AW'(7), '0);
    issue(5'd1, 1'b1, AW'(0), '0, '0, DW'(16'h8000));
    issue(5'd1, 1'b1, AW'(1), '0, '0, DW'(16'h8002));
    issue(5'd2, 1'b0, AW'(2), AW'(0), AW'(1), '0);
    issue(5'd1, 1'b1, AW'(0), '0, '0, DW'(0));
    issue(5'd1, 1'b1, AW'(1), '0, '0, DW'(1));
    issue(5'd3, 1'b0, AW'(3), AW'(0), AW'(1), '0);
    issue(5'd1, 1'b1, AW'(6), '0, '0, DW'(16'h1234));
    issue(5'd4, 1'b1, AW'(7), AW'(6), '0, DW'(16'h0100));
    issue(5'd0, 1'b0, AW'(5), '0, '0, '0);
    issue(5'd20, 1'b1, AW'(0), AW'(1), '0, DW'(9));
    issue(5'd1, 1'b1, AW'(8), '0, '0, '1);
    issue(5'd4, 1'b0, AW'(9), AW'(8), AW'(8), '0);

    // Random instruction stream.
    for (int i = 0; i < 300; i++) begin
      o = 5'($urandom_range(0, 13));
      if (o > 5'd11) o = 5'($urandom_range(12, 31));
      issue(o, 1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom), AW'($urandom),
            pick_imm());
    end

    // Reset in the middle of a multiply: nothing may be written back.
    op = 5'd4; imm_mode = 1'b1; rdst = AW'(3); rsrc1 = AW'(8); imm = DW'(3);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_before_rst", in_ready, 0);
    sys_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sys_rst = 1'b0;
    model_reset();
    chk("midmul_rst_in_ready", in_ready, 1);
    chk("midmul_rst_done", done, 0);
    chk("midmul_rst_flags", flags, 0);
    chk("midmul_rst_sgpr", sgpr, 0);
    for (int i = 0; i < RC; i++) begin
      drv_addr = AW'(i);
      #1;
      chk("midmul_rst_gpr", dbg_data, 0);
    end
    repeat (DW + 4) @(negedge clk);

    // Short random tail after reset, then compare the whole register file.
    for (int i = 0; i < 40; i++) begin
      o = 5'($urandom_range(0, 11));
      issue(o, 1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom), AW'($urandom),
            pick_imm());
    end
    repeat (DW + 4) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    for (int i = 0; i < RC; i++) begin
      drv_addr = AW'(i);
      #1;
      chk("final_gpr", dbg_data, m_gpr[i]);
    end
    chk("final_sgpr", sgpr, m_sgpr);
    chk("final_flags", flags, m_flags);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
